// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI-lite round-robin arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/axi_arbiter_rr.sv
// Two-master AXI-lite arbiter: one registered grant per complete transaction,
// round-robin priority, all handshakes of the non-granted master gated off.
module axi_arbiter_rr
    import axi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic [ADDR_WIDTH-1:0]   axi1_AW_ADDR,
    input  logic                    axi1_AW_VALID,
    output logic                    axi1_AW_READY,
    input  logic [DATA_WIDTH-1:0]   axi1_W_DATA,
    input  logic [DATA_WIDTH/8-1:0] axi1_W_STRB,
    input  logic                    axi1_W_VALID,
    output logic                    axi1_W_READY,
    output logic                    axi1_B_VALID,
    input  logic                    axi1_B_READY,
    input  logic [ADDR_WIDTH-1:0]   axi1_AR_ADDR,
    input  logic                    axi1_AR_VALID,
    output logic                    axi1_AR_READY,
    output logic [DATA_WIDTH-1:0]   axi1_R_DATA,
    output logic                    axi1_R_VALID,
    input  logic                    axi1_R_READY,
    input  logic [ADDR_WIDTH-1:0]   axi2_AW_ADDR,
    input  logic                    axi2_AW_VALID,
    output logic                    axi2_AW_READY,
    input  logic [DATA_WIDTH-1:0]   axi2_W_DATA,
    input  logic [DATA_WIDTH/8-1:0] axi2_W_STRB,
    input  logic                    axi2_W_VALID,
    output logic                    axi2_W_READY,
    output logic                    axi2_B_VALID,
    input  logic                    axi2_B_READY,
    input  logic [ADDR_WIDTH-1:0]   axi2_AR_ADDR,
    input  logic                    axi2_AR_VALID,
    output logic                    axi2_AR_READY,
    output logic [DATA_WIDTH-1:0]   axi2_R_DATA,
    output logic                    axi2_R_VALID,
    input  logic                    axi2_R_READY,
    output logic [ADDR_WIDTH-1:0]   s_AW_ADDR,
    output logic                    s_AW_VALID,
    input  logic                    s_AW_READY,
    output logic [DATA_WIDTH-1:0]   s_W_DATA,
    output logic [DATA_WIDTH/8-1:0] s_W_STRB,
    output logic                    s_W_VALID,
    input  logic                    s_W_READY,
    input  logic                    s_B_VALID,
    output logic                    s_B_READY,
    output logic [ADDR_WIDTH-1:0]   s_AR_ADDR,
    output logic                    s_AR_VALID,
    input  logic                    s_AR_READY,
    input  logic [DATA_WIDTH-1:0]   s_R_DATA,
    input  logic                    s_R_VALID,
    output logic                    s_R_READY,
    output logic                    channel,
    output logic                    busy
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_t state, state_nxt;
    logic   last_grant, aw_done, w_done, ar_done;
    logic   pick, xact_end, ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic [1:0] req;

    // Masters gathered into index-by-grant vectors (bit 0 = master 1).
    logic [1:0] ar_valid, aw_valid, w_valid, r_ready, b_ready;
    logic [1:0][ADDR_WIDTH-1:0] ar_addr, aw_addr;
    logic [1:0][DATA_WIDTH-1:0] w_data, r_data_m;
    logic [1:0][STRB_W-1:0]     w_strb;
    logic [1:0] ar_ready_m, aw_ready_m, w_ready_m, r_valid_m, b_valid_m;

    assign ar_valid = {axi2_AR_VALID, axi1_AR_VALID};
    assign aw_valid = {axi2_AW_VALID, axi1_AW_VALID};
    assign w_valid  = {axi2_W_VALID,  axi1_W_VALID};
    assign r_ready  = {axi2_R_READY,  axi1_R_READY};
    assign b_ready  = {axi2_B_READY,  axi1_B_READY};
    assign ar_addr  = {axi2_AR_ADDR,  axi1_AR_ADDR};
    assign aw_addr  = {axi2_AW_ADDR,  axi1_AW_ADDR};
    assign w_data   = {axi2_W_DATA,   axi1_W_DATA};
    assign w_strb   = {axi2_W_STRB,   axi1_W_STRB};

    assign {axi2_AR_READY, axi1_AR_READY} = ar_ready_m;
    assign {axi2_AW_READY, axi1_AW_READY} = aw_ready_m;
    assign {axi2_W_READY,  axi1_W_READY}  = w_ready_m;
    assign {axi2_R_VALID,  axi1_R_VALID}  = r_valid_m;
    assign {axi2_B_VALID,  axi1_B_VALID}  = b_valid_m;
    assign axi1_R_DATA = r_data_m[M_IFU];
    assign axi2_R_DATA = r_data_m[M_LSU];

    assign busy     = (state != IDLE);
    assign ar_hs    = s_AR_VALID & s_AR_READY;
    assign aw_hs    = s_AW_VALID & s_AW_READY;
    assign w_hs     = s_W_VALID & s_W_READY;
    assign r_hs     = (state == RD) & s_R_VALID & r_ready[channel];
    assign b_hs     = (state == WR) & s_B_VALID & b_ready[channel];
    assign xact_end = r_hs | b_hs;

    // On contention the master that did not hold the last grant wins.
    always_comb begin
        req       = ar_valid | aw_valid;
        pick      = (&req) ? ~last_grant : req[M_LSU];
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = ar_valid[pick] ? RD : WR;
            RD:      if (r_hs) state_nxt = IDLE;
            WR:      if (b_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            channel    <= M_IFU;
            last_grant <= M_LSU;
            ar_done    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            if (state == IDLE && |req) channel <= pick;
            if (xact_end) begin
                last_grant <= channel;
                ar_done    <= 1'b0;
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
            end else begin
                if (ar_hs) ar_done <= 1'b1;
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
        end
    end

    // Only the granted master's lane is ever driven; everything else stays 0.
    always_comb begin
        s_AR_ADDR  = '0;
        s_AW_ADDR  = '0;
        s_W_DATA   = '0;
        s_W_STRB   = '0;
        s_AR_VALID = 1'b0;
        s_AW_VALID = 1'b0;
        s_W_VALID  = 1'b0;
        s_R_READY  = 1'b0;
        s_B_READY  = 1'b0;
        ar_ready_m = '0;
        aw_ready_m = '0;
        w_ready_m  = '0;
        r_valid_m  = '0;
        b_valid_m  = '0;
        r_data_m   = '0;
        if (busy) begin
            s_AR_ADDR         = ar_addr[channel];
            s_AW_ADDR         = aw_addr[channel];
            s_W_DATA          = w_data[channel];
            s_W_STRB          = w_strb[channel];
            r_data_m[channel] = s_R_DATA;
        end
        case (state)
            RD: begin
                s_AR_VALID          = ar_valid[channel] & ~ar_done;
                ar_ready_m[channel] = s_AR_READY & ~ar_done;
                s_R_READY           = r_ready[channel];
                r_valid_m[channel]  = s_R_VALID;
            end
            WR: begin
                s_AW_VALID          = aw_valid[channel] & ~aw_done;
                aw_ready_m[channel] = s_AW_READY & ~aw_done;
                s_W_VALID           = w_valid[channel] & ~w_done;
                w_ready_m[channel]  = s_W_READY & ~w_done;
                s_B_READY           = b_ready[channel];
                b_valid_m[channel]  = s_B_VALID;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter_rr.sv
// Bench for axi_arbiter_rr: reset checks, a directed vector table, a reset
// mid-read sequence and random traffic against a transaction-level model.
module tb_axi_arbiter_rr;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic CLK = 1'b0;
    logic RESETN;
    always #5 CLK = ~CLK;

    logic [AW-1:0] ar_addr [1:2];
    logic [AW-1:0] aw_addr [1:2];
    logic [DW-1:0] w_data  [1:2];
    logic [SW-1:0] w_strb  [1:2];
    logic ar_valid [1:2];
    logic aw_valid [1:2];
    logic w_valid  [1:2];
    logic r_ready  [1:2];
    logic b_ready  [1:2];
    logic s_AW_READY, s_W_READY, s_B_VALID, s_AR_READY, s_R_VALID;
    logic [DW-1:0] s_R_DATA;

    wire [2:1] ar_ready, aw_ready, w_ready, r_valid, b_valid;
    wire [DW-1:0] r_data1, r_data2;
    wire [AW-1:0] s_AW_ADDR, s_AR_ADDR;
    wire [DW-1:0] s_W_DATA;
    wire [SW-1:0] s_W_STRB;
    wire s_AW_VALID, s_W_VALID, s_B_READY, s_AR_VALID, s_R_READY, channel, busy;

    axi_arbiter_rr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .axi1_AW_ADDR(aw_addr[1]), .axi1_AW_VALID(aw_valid[1]), .axi1_AW_READY(aw_ready[1]),
        .axi1_W_DATA(w_data[1]), .axi1_W_STRB(w_strb[1]), .axi1_W_VALID(w_valid[1]),
        .axi1_W_READY(w_ready[1]), .axi1_B_VALID(b_valid[1]), .axi1_B_READY(b_ready[1]),
        .axi1_AR_ADDR(ar_addr[1]), .axi1_AR_VALID(ar_valid[1]), .axi1_AR_READY(ar_ready[1]),
        .axi1_R_DATA(r_data1), .axi1_R_VALID(r_valid[1]), .axi1_R_READY(r_ready[1]),
        .axi2_AW_ADDR(aw_addr[2]), .axi2_AW_VALID(aw_valid[2]), .axi2_AW_READY(aw_ready[2]),
        .axi2_W_DATA(w_data[2]), .axi2_W_STRB(w_strb[2]), .axi2_W_VALID(w_valid[2]),
        .axi2_W_READY(w_ready[2]), .axi2_B_VALID(b_valid[2]), .axi2_B_READY(b_ready[2]),
        .axi2_AR_ADDR(ar_addr[2]), .axi2_AR_VALID(ar_valid[2]), .axi2_AR_READY(ar_ready[2]),
        .axi2_R_DATA(r_data2), .axi2_R_VALID(r_valid[2]), .axi2_R_READY(r_ready[2]),
        .s_AW_ADDR(s_AW_ADDR), .s_AW_VALID(s_AW_VALID), .s_AW_READY(s_AW_READY),
        .s_W_DATA(s_W_DATA), .s_W_STRB(s_W_STRB), .s_W_VALID(s_W_VALID), .s_W_READY(s_W_READY),
        .s_B_VALID(s_B_VALID), .s_B_READY(s_B_READY),
        .s_AR_ADDR(s_AR_ADDR), .s_AR_VALID(s_AR_VALID), .s_AR_READY(s_AR_READY),
        .s_R_DATA(s_R_DATA), .s_R_VALID(s_R_VALID), .s_R_READY(s_R_READY),
        .channel(channel), .busy(busy)
    );

    // channel is only meaningful while busy, so it is masked in the compare.
    wire [16:0] act_hs = {busy, busy & channel,
                          s_AR_VALID, s_AW_VALID, s_W_VALID, s_R_READY, s_B_READY,
                          ar_ready[1], aw_ready[1], w_ready[1], r_valid[1], b_valid[1],
                          ar_ready[2], aw_ready[2], w_ready[2], r_valid[2], b_valid[2]};
    wire [327:0] act_bus = {s_AR_ADDR, s_AW_ADDR, s_W_DATA, s_W_STRB, r_data1, r_data2};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [327:0] act, input logic [327:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: who owns the slave, what kind of op, which
    // phases have already been accepted, and whose turn it is on a tie.
    int owner = 0;     // 0 = nobody, else master number 1 or 2
    int favored = 1;   // master that wins when both ask
    bit is_read, got_ar, got_aw, got_w;

    task automatic expect_now(output logic [16:0] e_hs, output logic [327:0] e_bus);
        bit [4:0] m [1:2];
        bit sarv, sawv, swv, srr, sbr;
        logic [DW-1:0] rd1, rd2;
        m[1] = '0; m[2] = '0;
        {sarv, sawv, swv, srr, sbr} = '0;
        e_hs = '0;
        e_bus = '0;
        if (RESETN === 1'b1 && owner != 0) begin
            if (is_read) begin
                sarv = ar_valid[owner] && !got_ar;
                srr  = r_ready[owner];
                m[owner][4] = s_AR_READY && !got_ar;
                m[owner][1] = s_R_VALID;
            end else begin
                sawv = aw_valid[owner] && !got_aw;
                swv  = w_valid[owner] && !got_w;
                sbr  = b_ready[owner];
                m[owner][3] = s_AW_READY && !got_aw;
                m[owner][2] = s_W_READY && !got_w;
                m[owner][0] = s_B_VALID;
            end
            e_hs = {1'b1, owner == 2, sarv, sawv, swv, srr, sbr, m[1], m[2]};
            rd1 = (owner == 1) ? s_R_DATA : '0;
            rd2 = (owner == 2) ? s_R_DATA : '0;
            e_bus = {ar_addr[owner], aw_addr[owner], w_data[owner], w_strb[owner], rd1, rd2};
        end
    endtask

    task automatic model_edge();
        bit r1, r2;
        int p;
        if (owner == 0) begin
            r1 = ar_valid[1] || aw_valid[1];
            r2 = ar_valid[2] || aw_valid[2];
            p = (r1 && r2) ? favored : r1 ? 1 : r2 ? 2 : 0;
            if (p != 0) begin
                owner = p;
                is_read = ar_valid[p];
                {got_ar, got_aw, got_w} = '0;
            end
        end else if (is_read ? (s_R_VALID && r_ready[owner]) : (s_B_VALID && b_ready[owner])) begin
            favored = 3 - owner;
            owner = 0;
        end else if (is_read) begin
            if (ar_valid[owner] && s_AR_READY) got_ar = 1'b1;
        end else begin
            if (aw_valid[owner] && s_AW_READY) got_aw = 1'b1;
            if (w_valid[owner] && s_W_READY) got_w = 1'b1;
        end
    endtask

    // Check the current cycle against the model, then advance one clock.
    task automatic step(input string name);
        logic [16:0]  e_hs;
        logic [327:0] e_bus;
        #1;
        expect_now(e_hs, e_bus);
        chk({name, "_hs"}, 328'(act_hs), 328'(e_hs));
        chk({name, "_bus"}, act_bus, e_bus);
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    // Vector bits: m1{ar aw w rr br} m2{ar aw w rr br} slave{arr awr wr rv bv}
    task automatic apply(input logic [14:0] v);
        {ar_valid[1], aw_valid[1], w_valid[1], r_ready[1], b_ready[1],
         ar_valid[2], aw_valid[2], w_valid[2], r_ready[2], b_ready[2],
         s_AR_READY, s_AW_READY, s_W_READY, s_R_VALID, s_B_VALID} = v;
    endtask

    typedef struct {
        logic [14:0] in;
        logic [16:0] exp;  // {busy ch} {sarv sawv swv srr sbr} m1{..} m2{..}
    } vec_t;
    vec_t tab [20];

    initial begin
        tab[0]  = '{15'b10011_10011_00000, 17'b00_00000_00000_00000};
        tab[1]  = '{15'b10011_10011_10000, 17'b10_10010_10000_00000};
        tab[2]  = '{15'b00011_10011_10010, 17'b10_00010_00010_00000};
        tab[3]  = '{15'b00011_10011_00000, 17'b00_00000_00000_00000};
        tab[4]  = '{15'b00011_10011_10000, 17'b11_10010_00000_10000};
        tab[5]  = '{15'b00011_00011_00010, 17'b11_00010_00000_00010};
        tab[6]  = '{15'b00111_00011_00100, 17'b00_00000_00000_00000};
        tab[7]  = '{15'b00111_00011_00100, 17'b00_00000_00000_00000};
        tab[8]  = '{15'b01111_00011_00000, 17'b00_00000_00000_00000};
        tab[9]  = '{15'b01111_00011_00100, 17'b10_01101_00100_00000};
        tab[10] = '{15'b01011_00011_01000, 17'b10_01001_01000_00000};
        tab[11] = '{15'b00011_00011_00001, 17'b10_00001_00001_00000};
        tab[12] = '{15'b10011_11111_00000, 17'b00_00000_00000_00000};
        tab[13] = '{15'b10011_11111_10000, 17'b11_10010_00000_10000};
        tab[14] = '{15'b10011_01111_00010, 17'b11_00010_00000_00010};
        tab[15] = '{15'b10011_01111_00000, 17'b00_00000_00000_00000};
        tab[16] = '{15'b10011_01111_10010, 17'b10_10010_10010_00000};
        tab[17] = '{15'b00011_01111_00000, 17'b00_00000_00000_00000};
        tab[18] = '{15'b00011_01111_01101, 17'b11_01101_00000_01101};
        tab[19] = '{15'b00011_00011_00000, 17'b00_00000_00000_00000};

        // Reset with every input asserted: all outputs must be 0 at once.
        RESETN = 1'b0;
        ar_addr[1] = 64'h8000_0000; ar_addr[2] = 64'h8000_1000;
        aw_addr[1] = 64'h8000_0040; aw_addr[2] = 64'h8000_2000;
        w_data[1]  = 64'h1111_2222_3333_4444; w_data[2] = 64'h5555_6666_7777_8888;
        w_strb[1]  = 8'h0F; w_strb[2] = 8'hF0;
        s_R_DATA   = 64'hDEAD_BEEF_CAFE_0001;
        apply(15'h7FFF);
        #3;
        chk("reset_hs", 328'(act_hs), '0);
        chk("reset_bus", act_bus, '0);
        chk("reset_channel", 328'(channel), '0);
        @(posedge CLK);
        #1 RESETN = 1'b1;

        for (int i = 0; i < 20; i++) begin
            apply(tab[i].in);
            #1;
            chk($sformatf("vec%0d", i), 328'(act_hs), 328'(tab[i].exp));
            if (i == 1) chk("vec1_ar_addr", 328'(s_AR_ADDR), 328'(64'h8000_0000));
            step($sformatf("vec%0d_model", i));
        end

        // Reset lands after the AR handshake, while R is still pending.
        apply(15'b10011_00011_00000);
        step("arst_req");
        apply(15'b10011_00011_10000);
        step("arst_ar");
        apply(15'b00011_00011_00010);
        #1;
        RESETN = 1'b0;
        owner = 0;
        favored = 1;
        #1;
        chk("arst_hs", 328'(act_hs), '0);
        chk("arst_bus", act_bus, '0);
        @(posedge CLK);
        #1 RESETN = 1'b1;
        apply(15'b00011_10011_00000);
        step("arst_idle");
        apply(15'b00011_10011_10000);
        #1;
        chk("arst_regrant", 328'({busy, channel}), 328'(2'b11));
        step("arst_m2");

        for (int n = 0; n < 1500; n++) begin
            for (int m = 1; m <= 2; m++) begin
                ar_valid[m] = 1'($urandom_range(0, 1));
                aw_valid[m] = 1'($urandom_range(0, 1));
                w_valid[m]  = 1'($urandom_range(0, 1));
                r_ready[m]  = 1'($urandom_range(0, 1));
                b_ready[m]  = 1'($urandom_range(0, 1));
                ar_addr[m]  = {$urandom, $urandom};
                aw_addr[m]  = {$urandom, $urandom};
                w_data[m]   = {$urandom, $urandom};
                w_strb[m]   = 8'($urandom);
            end
            s_AR_READY = 1'($urandom_range(0, 1));
            s_AW_READY = 1'($urandom_range(0, 1));
            s_W_READY  = 1'($urandom_range(0, 1));
            s_R_VALID  = 1'($urandom_range(0, 1));
            s_B_VALID  = 1'($urandom_range(0, 1));
            s_R_DATA   = {$urandom, $urandom};
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
